puf_challenge_ctrl: RTL and testbench

Initiator side of the arbiter PUF. It generates challenge vectors from a seeded LFSR and drives the PUF's race input and arbiter reset. It collects each synchronized response bit and assembles a RESP_BITS-wide response word. It sits between the host/enrollment logic and the PUF's challenge, in, reset and out pins.

---
 rtl/puf_challenge_ctrl_if.sv | 31 +++
 rtl/puf_challenge_ctrl.sv | 128 ++++++++++++
 tb/tb_puf_challenge_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_challenge_ctrl_if.sv
// rtl/puf_challenge_ctrl_if.sv - host and PUF pin bundle for puf_challenge_ctrl
interface puf_challenge_ctrl_if #(
  parameter int N         = 128,
  parameter int RESP_BITS = 32
);
  // host request side
  logic                 start;
  logic                 seed_load;
  logic [N-1:0]         seed;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;

  // PUF pins
  logic [N-1:0]         puf_sel;
  logic                 puf_in;
  logic                 puf_reset;
  logic                 puf_out;

  // host / PUF model side
  modport master (
    output start, seed_load, seed, puf_out,
    input  busy, done, response, puf_sel, puf_in, puf_reset
  );

  // controller side
  modport slave (
    input  start, seed_load, seed, puf_out,
    output busy, done, response, puf_sel, puf_in, puf_reset
  );
endinterface

// File: rtl/puf_challenge_ctrl.sv
// rtl/puf_challenge_ctrl.sv - arbiter PUF challenge generator and response collector
module puf_challenge_ctrl #(
  parameter int           N             = 128,
  parameter int           RESP_BITS     = 32,
  parameter int           SETTLE_CYCLES = 8,
  parameter logic [N-1:0] TAPS          = 128'hA000_0000_0000_0000_0000_0028_0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  puf_challenge_ctrl_if.slave bus
);

  // phase counter must reach SETTLE_CYCLES+1 in FIRE
  localparam int PW = $clog2(SETTLE_CYCLES + 2);
  // bit counter must reach RESP_BITS
  localparam int BW = $clog2(RESP_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOW,
    FIRE,
    SAMPLE,
    DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PW-1:0]        phase_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [N-1:0]         chal;
  logic [N-1:0]         seed_fix;
  logic [RESP_BITS-1:0] response;
  logic                 sync_d;
  logic                 sync_q;
  logic                 low_last;
  logic                 fire_last;
  logic                 bit_last;

  // an all-zero seed would lock the LFSR, so it is replaced by 1
  assign seed_fix  = (bus.seed == '0) ? N'(1) : bus.seed;

  assign low_last  = (phase_cnt == PW'(SETTLE_CYCLES - 1));
  assign fire_last = (phase_cnt == PW'(SETTLE_CYCLES + 1));
  assign bit_last  = (bit_cnt == BW'(RESP_BITS - 1));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: fixed-length phases per response bit
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ARM;
      ARM:     state_next = LOW;
      LOW:     if (low_last) state_next = FIRE;
      FIRE:    if (fire_last) state_next = SAMPLE;
      SAMPLE:  state_next = bit_last ? DONE : ARM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // two-flop synchronizer for the asynchronous arbiter output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= bus.puf_out;
      sync_q <= sync_d;
    end
  end

  // phase timer counts cycles spent in LOW and FIRE, cleared on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if ((state == LOW || state == FIRE) && state_next == state) begin
      phase_cnt <= phase_cnt + PW'(1);
    end else begin
      phase_cnt <= '0;
    end
  end

  // challenge LFSR, response shift register and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chal     <= N'(1);
      response <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // seed load takes effect before a same-cycle start is acted on
          if (bus.seed_load) chal <= seed_fix;
          if (bus.start) begin
            response <= '0;
            bit_cnt  <= '0;
          end
        end
        SAMPLE: begin
          // first collected bit ends up at the MSB
          response <= (response << 1) | RESP_BITS'(sync_q);
          // challenge only moves here, while puf_in is low
          chal     <= {chal[N-2:0], ^(chal & TAPS)};
          bit_cnt  <= bit_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

  // all outputs come from registers or a decode of the state register
  assign bus.puf_sel   = chal;
  assign bus.puf_in    = (state == FIRE);
  assign bus.puf_reset = (state != LOW) && (state != FIRE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.response  = response;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// tb/tb_puf_challenge_ctrl.sv - self-checking bench for puf_challenge_ctrl
module tb_puf_challenge_ctrl;

  localparam int           N    = 128;
  localparam int           RB   = 32;
  localparam int           S    = 8;
  localparam logic [N-1:0] TAPS = 128'hA000_0000_0000_0000_0000_0028_0000_0000;
  localparam int           BOUND = 2000;

  logic clk = 1'b0;
  logic reset;

  puf_challenge_ctrl_if #(.N(N), .RESP_BITS(RB)) dut_if ();

  puf_challenge_ctrl #(
    .N(N), .RESP_BITS(RB), .SETTLE_CYCLES(S), .TAPS(TAPS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stub PUF: 0 = latch puf_sel[0], 1 = tied high, 2 = random bit per launch
  int   mode = 0;
  logic stub_q = 1'b0;
  bit   rand_bits[$];

  assign dut_if.puf_out = (mode == 1) ? 1'b1 : stub_q;

  always @(posedge dut_if.puf_in) begin
    if (mode == 2) begin
      stub_q = 1'($urandom_range(0, 1));
      rand_bits.push_back(stub_q);
    end else begin
      stub_q = dut_if.puf_sel[0];
    end
  end

  always @(posedge dut_if.puf_reset) stub_q = 1'b0;

  // waveform monitors, sampled on the falling edge
  int          busy_cycles = 0;
  int          done_cnt = 0;
  int          hi_run = 0, lo_run = 0;
  int          hi_seen = 0, hi_bad = 0, lo_seen = 0, lo_bad = 0;
  int          sel_bad = 0;
  logic        prev_in = 1'b0;
  logic [N-1:0] prev_sel = '0;

  always @(negedge clk) begin
    if (dut_if.busy) busy_cycles++;
    if (dut_if.done) done_cnt++;
    if (dut_if.puf_in) begin
      if (!prev_in) begin
        lo_seen++;
        if (lo_run != S) lo_bad++;
      end
      hi_run++;
    end else begin
      if (prev_in) begin
        hi_seen++;
        if (hi_run != S + 2) hi_bad++;
      end
      hi_run = 0;
    end
    if (!dut_if.puf_in && !dut_if.puf_reset) lo_run++;
    else lo_run = 0;
    if (dut_if.puf_in && prev_in && dut_if.puf_sel !== prev_sel) sel_bad++;
    prev_in  = dut_if.puf_in;
    prev_sel = dut_if.puf_sel;
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: challenge sequence and expected words from the stated rules
  logic [N-1:0]  model_chal;
  logic [RB-1:0] exp_resp;

  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] c);
    return {c[N-2:0], ^(c & TAPS)};
  endfunction

  task automatic model_sel0_word();
    exp_resp = '0;
    for (int i = 0; i < RB; i++) begin
      exp_resp[RB-1-i] = model_chal[0];
      model_chal = lfsr_next(model_chal);
    end
  endtask

  task automatic model_rand_word();
    exp_resp = '0;
    for (int i = 0; i < rand_bits.size() && i < RB; i++) exp_resp[RB-1-i] = rand_bits[i];
    for (int i = 0; i < RB; i++) model_chal = lfsr_next(model_chal);
  endtask

  // run results
  logic [RB-1:0] got_resp;
  logic [N-1:0]  got_sel;
  int            got_busy;
  int            busy_low;
  bit            got;

  task automatic launch(input bit load, input bit together, input logic [N-1:0] sd);
    @(negedge clk);
    if (load && !together) begin
      dut_if.seed_load = 1'b1;
      dut_if.seed      = sd;
      @(negedge clk);
      dut_if.seed_load = 1'b0;
    end
    if (load && together) begin
      dut_if.seed_load = 1'b1;
      dut_if.seed      = sd;
    end
    if (load) model_chal = (sd == '0) ? N'(1) : sd;
    rand_bits.delete();
    busy_cycles = 0;
    done_cnt    = 0;
    hi_seen = 0; hi_bad = 0; lo_seen = 0; lo_bad = 0;
    dut_if.start = 1'b1;
    @(negedge clk);
    dut_if.start     = 1'b0;
    dut_if.seed_load = 1'b0;
  endtask

  task automatic wait_done(input bit pulses);
    got      = 1'b0;
    busy_low = 0;
    for (int k = 0; k < BOUND && !got; k++) begin
      dut_if.start = pulses && (k == 5 || k == 100 || k == 300);
      @(negedge clk);
      #1;
      if (!dut_if.busy) busy_low++;
      if (dut_if.done) begin
        got      = 1'b1;
        got_resp = dut_if.response;
        got_sel  = dut_if.puf_sel;
        got_busy = busy_cycles;
      end
    end
    dut_if.start = 1'b0;
    check("done_within_bound", N'(got), N'(1));
  endtask

  initial begin
    reset            = 1'b1;
    dut_if.start     = 1'b0;
    dut_if.seed_load = 1'b0;
    dut_if.seed      = '0;
    model_chal       = N'(1);
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", N'(dut_if.busy), N'(0));
    check("rst_done", N'(dut_if.done), N'(0));
    check("rst_puf_in", N'(dut_if.puf_in), N'(0));
    check("rst_puf_reset", N'(dut_if.puf_reset), N'(1));
    check("rst_response", N'(dut_if.response), N'(0));
    check("rst_puf_sel", dut_if.puf_sel, N'(1));
    @(negedge clk);
    reset = 1'b0;

    // seed = 1 with the sel[0] stub
    mode = 0;
    launch(1'b1, 1'b0, N'(1));
    model_sel0_word();
    wait_done(1'b0);
    check("A_response", N'(got_resp), N'(32'h8000_0000));
    check("A_model", N'(got_resp), N'(exp_resp));
    check("A_busy_cycles", N'(got_busy), N'(RB * (2 * S + 4) + 1));
    check("A_sel_at_done", got_sel, 128'h1_0000_0000);
    check("A_busy_low", N'(busy_low), N'(0));

    // tied-high response from reset defaults, plus launch timing
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    model_chal = N'(1);
    mode       = 1;
    launch(1'b0, 1'b0, '0);
    model_sel0_word();
    wait_done(1'b0);
    check("B_response", N'(got_resp), N'(32'hFFFF_FFFF));
    check("B_hi_seen", N'(hi_seen), N'(RB));
    check("B_hi_bad", N'(hi_bad), N'(0));
    check("B_lo_seen", N'(lo_seen), N'(RB));
    check("B_lo_bad", N'(lo_bad), N'(0));

    // zero seed behaves as seed 1
    mode = 0;
    launch(1'b1, 1'b0, '0);
    model_sel0_word();
    wait_done(1'b0);
    check("C_response", N'(got_resp), N'(32'h8000_0000));
    check("C_sel_at_done", got_sel, 128'h1_0000_0000);

    // extra starts during a run are ignored
    launch(1'b1, 1'b0, N'(1));
    model_sel0_word();
    wait_done(1'b1);
    check("D_response", N'(got_resp), N'(32'h8000_0000));
    check("D_busy_low", N'(busy_low), N'(0));
    repeat (3) @(negedge clk);
    #1;
    check("D_idle_after", N'(dut_if.busy), N'(0));
    check("D_done_count", N'(done_cnt), N'(1));

    // reset asserted during bit 12
    launch(1'b1, 1'b0, N'(1));
    repeat (12 * (2 * S + 4) + 5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("E_busy", N'(dut_if.busy), N'(0));
    check("E_puf_reset", N'(dut_if.puf_reset), N'(1));
    check("E_puf_in", N'(dut_if.puf_in), N'(0));
    check("E_response", N'(dut_if.response), N'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (700) @(negedge clk);
    #1;
    check("E_no_done", N'(done_cnt), N'(0));
    model_chal = N'(1);
    launch(1'b0, 1'b0, '0);
    model_sel0_word();
    wait_done(1'b0);
    check("E_fresh_response", N'(got_resp), N'(32'h8000_0000));

    // random seed loaded together with start, then a continuation run
    for (int r = 0; r < 2; r++) begin
      logic [N-1:0] sd;
      sd = {$urandom, $urandom, $urandom, $urandom};
      launch(1'b1, 1'b1, sd);
      model_sel0_word();
      wait_done(1'b0);
      check("F_first_word", N'(got_resp), N'(exp_resp));
      launch(1'b0, 1'b0, '0);
      model_sel0_word();
      wait_done(1'b0);
      check("F_second_word", N'(got_resp), N'(exp_resp));
      check("F_sel_at_done", got_sel, model_chal);
    end

    // random PUF bits
    mode = 2;
    launch(1'b0, 1'b0, '0);
    wait_done(1'b0);
    model_rand_word();
    check("G_bits_seen", N'(rand_bits.size()), N'(RB));
    check("G_response", N'(got_resp), N'(exp_resp));
    check("G_sel_at_done", got_sel, model_chal);

    check("sel_stable_while_fire", N'(sel_bad), N'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
